// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned DEF_PAT_LEN = 4;
  localparam logic [31:0] DEF_PATTERN = 32'b1010;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_STEP,
    ACT_MATCH
  } det_act_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Longest prefix of pattern, shorter than len, that ends the string
  // (first k pattern bits followed by b); covers both mismatch fallback and post-match overlap.
  function automatic int unsigned kmp_next(input logic [31:0] pattern, input int unsigned len,
                                           input int unsigned k, input logic b);
    logic [31:0] s;
    int unsigned n;
    int unsigned best;
    bit          ok;
    s    = '0;
    n    = k + 1;
    best = 0;
    for (int unsigned i = 0; i < k; i++) s[5'(i)] = pattern[5'(len - 1 - i)];
    s[5'(k)] = b;
    for (int unsigned j = 1; j <= n; j++) begin
      if (j < len) begin
        ok = 1'b1;
        for (int unsigned t = 0; t < j; t++) begin
          if (s[5'(n - j + t)] != pattern[5'(len - 1 - t)]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with async reset and sync clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised MSB-first serial pattern detector with sample enable, sync clear,
// selectable overlap and Mealy/Moore detect, plus a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int unsigned PAT_LEN   = DEF_PAT_LEN,
  parameter  logic [31:0] PATTERN   = DEF_PATTERN,
  parameter  bit          OVERLAP   = 1'b1,
  parameter  bit          MOORE     = 1'b0,
  parameter  int unsigned COUNT_W   = 8,
  localparam int unsigned PAT_LEN_W = clog2_min1(PAT_LEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 in,
  output logic                 detect,
  output logic [COUNT_W-1:0]   match_count,
  output logic [PAT_LEN_W-1:0] partial
);

  localparam logic [PAT_LEN_W-1:0] LAST = PAT_LEN_W'(PAT_LEN - 1);

  if ((PAT_LEN < 2) || (PAT_LEN > 32) || ((PATTERN >> PAT_LEN) != '0)) begin : g_param_check
    $fatal(1, "seq_detector_param: PAT_LEN must be 2..32 and PATTERN must fit in PAT_LEN bits");
  end

  logic [PAT_LEN_W-1:0] w_nxt0 [PAT_LEN];
  logic [PAT_LEN_W-1:0] w_nxt1 [PAT_LEN];

  // Next-prefix tables, one entry per (k, bit), resolved entirely at elaboration.
  for (genvar gk = 0; gk < PAT_LEN; gk++) begin : g_tbl
    localparam int unsigned NXT0 = kmp_next(PATTERN, PAT_LEN, gk, 1'b0);
    localparam int unsigned NXT1 = kmp_next(PATTERN, PAT_LEN, gk, 1'b1);
    assign w_nxt0[gk] = PAT_LEN_W'(NXT0);
    assign w_nxt1[gk] = PAT_LEN_W'(NXT1);
  end

  logic [PAT_LEN_W-1:0] r_k;
  logic                 r_det;
  logic [PAT_LEN_W-1:0] w_k_nxt;
  logic                 w_det_nxt;
  logic [PAT_LEN_W-1:0] w_step;
  logic                 w_match;
  logic                 w_inc;
  det_act_e             w_act;

  assign w_step  = in ? w_nxt1[r_k] : w_nxt0[r_k];
  assign w_match = en & ~clr & (r_k == LAST) & (in == PATTERN[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k   <= '0;
      r_det <= 1'b0;
    end else begin
      r_k   <= w_k_nxt;
      r_det <= w_det_nxt;
    end
  end

  always_comb begin
    w_act     = ACT_HOLD;
    w_k_nxt   = r_k;
    w_det_nxt = r_det;
    if (clr) begin
      w_act     = ACT_CLEAR;
      w_k_nxt   = '0;
      w_det_nxt = 1'b0;
    end else if (en) begin
      if (w_match) begin
        w_act     = ACT_MATCH;
        w_k_nxt   = OVERLAP ? w_step : '0;
        w_det_nxt = 1'b1;
      end else begin
        w_act     = ACT_STEP;
        w_k_nxt   = w_step;
        w_det_nxt = 1'b0;
      end
    end
  end

  assign w_inc   = (w_act == ACT_MATCH);
  assign detect  = MOORE ? r_det : w_match;
  assign partial = r_k;

  sat_counter #(
    .W(COUNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .inc  (w_inc),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Drives five differently configured detectors with one shared stream and checks each
// against a history-based reference model.
module tb_seq_detector_param;

  localparam int N = 5;
  localparam int unsigned PL  [N] = '{4, 4, 4, 5, 4};
  localparam logic [31:0] PP  [N] = '{32'b1010, 32'b1010, 32'b1010, 32'b11011, 32'b1010};
  localparam bit          POV [N] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam bit          PMO [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam int unsigned PCW [N] = '{8, 8, 8, 8, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic din = 1'b0;

  logic       det_a, det_b, det_c, det_d, det_e;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [1:0] cnt_e;
  logic [1:0] part_a, part_b, part_c, part_e;
  logic [2:0] part_d;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(4), .PATTERN(32'b1010), .OVERLAP(1'b1), .MOORE(1'b0), .COUNT_W(8)) u_a (
    .clk(clk), .reset(rst), .en(en), .clr(clr), .in(din),
    .detect(det_a), .match_count(cnt_a), .partial(part_a));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(32'b1010), .OVERLAP(1'b0), .MOORE(1'b0), .COUNT_W(8)) u_b (
    .clk(clk), .reset(rst), .en(en), .clr(clr), .in(din),
    .detect(det_b), .match_count(cnt_b), .partial(part_b));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(32'b1010), .OVERLAP(1'b1), .MOORE(1'b1), .COUNT_W(8)) u_c (
    .clk(clk), .reset(rst), .en(en), .clr(clr), .in(din),
    .detect(det_c), .match_count(cnt_c), .partial(part_c));
  seq_detector_param #(.PAT_LEN(5), .PATTERN(32'b11011), .OVERLAP(1'b1), .MOORE(1'b0), .COUNT_W(8)) u_d (
    .clk(clk), .reset(rst), .en(en), .clr(clr), .in(din),
    .detect(det_d), .match_count(cnt_d), .partial(part_d));
  seq_detector_param #(.PAT_LEN(4), .PATTERN(32'b1010), .OVERLAP(1'b1), .MOORE(1'b0), .COUNT_W(2)) u_e (
    .clk(clk), .reset(rst), .en(en), .clr(clr), .in(din),
    .detect(det_e), .match_count(cnt_e), .partial(part_e));

  logic        o_det  [N];
  logic [31:0] o_cnt  [N];
  logic [31:0] o_part [N];

  always_comb begin
    o_det[0] = det_a; o_det[1] = det_b; o_det[2] = det_c; o_det[3] = det_d; o_det[4] = det_e;
    o_cnt[0] = 32'(cnt_a); o_cnt[1] = 32'(cnt_b); o_cnt[2] = 32'(cnt_c);
    o_cnt[3] = 32'(cnt_d); o_cnt[4] = 32'(cnt_e);
    o_part[0] = 32'(part_a); o_part[1] = 32'(part_b); o_part[2] = 32'(part_c);
    o_part[3] = 32'(part_d); o_part[4] = 32'(part_e);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Model: the received bits since the last reset/clear (or non-overlapping match).
  logic [63:0] hist [N];
  int unsigned hlen [N];
  int unsigned mcnt [N];
  bit          mdet [N];

  function automatic bit ends_with(input logic [63:0] h, input int unsigned hl, input int unsigned j,
                                   input logic [31:0] pat, input int unsigned L);
    if (j > hl) return 1'b0;
    for (int unsigned t = 0; t < j; t++) begin
      if (h[6'(t)] != pat[5'(L - j + t)]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int unsigned exp_partial(input int i);
    for (int unsigned j = PL[i] - 1; j > 0; j--) begin
      if (ends_with(hist[i], hlen[i], j, PP[i], PL[i])) return j;
    end
    return 0;
  endfunction

  function automatic bit match_with(input int i, input logic b);
    logic [63:0] h2;
    int unsigned hl2;
    h2  = {hist[i][62:0], b};
    hl2 = (hlen[i] < 64) ? hlen[i] + 1 : 64;
    return ends_with(h2, hl2, PL[i], PP[i], PL[i]);
  endfunction

  task automatic model_clear(input int i, input bit all);
    hist[i] = '0;
    hlen[i] = 0;
    if (all) begin
      mcnt[i] = 0;
      mdet[i] = 1'b0;
    end
  endtask

  task automatic cycle(input bit e, input bit c, input bit d, input bit r);
    bit m [N];
    @(negedge clk);
    rst = r; en = e; clr = c; din = d;
    if (r) for (int i = 0; i < N; i++) model_clear(i, 1'b1);
    #1;
    for (int i = 0; i < N; i++) begin
      m[i] = e && !c && !r && match_with(i, d);
      check($sformatf("partial%0d", i), o_part[i], 32'(exp_partial(i)));
      check($sformatf("count%0d", i), o_cnt[i], 32'(mcnt[i]));
      check($sformatf("detect%0d", i), 32'(o_det[i]), PMO[i] ? 32'(mdet[i]) : 32'(m[i]));
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < N; i++) begin
        if (c) begin
          model_clear(i, 1'b1);
        end else if (e) begin
          hist[i] = {hist[i][62:0], d};
          hlen[i] = (hlen[i] < 64) ? hlen[i] + 1 : 64;
          if (m[i]) begin
            if (mcnt[i] < (32'd1 << PCW[i]) - 1) mcnt[i]++;
            if (!POV[i]) model_clear(i, 1'b0);
          end
          mdet[i] = m[i];
        end
      end
    end
  endtask

  task automatic feed(input string bits);
    for (int k = 0; k < bits.len(); k++) cycle(1'b1, 1'b0, bits[k] == 8'h31, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) model_clear(i, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    feed("10101010");
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    feed("111011");
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    // Enable gaps with junk data on the idle cycles.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // Reset mid-pattern, then clear with enable on the same cycle.
    feed("101");
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    feed("0");
    feed("101");
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    feed("0");
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    feed("10101010101010101010");
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
